// File: rtl/main_memory_ctrl_pkg.sv
// Shared widths, FSM encoding and block/word helpers for the main-memory responder.
`default_nettype none

package main_memory_ctrl_pkg;

  localparam int BLOCK_W = 128;
  localparam int WORD_W  = 32;
  localparam int IDX_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_DONE     = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  // Word 0 sits in the most significant slice of a block.
  function automatic logic [WORD_W-1:0] word_of(input logic [BLOCK_W-1:0] blk, input int w);
    return blk[BLOCK_W-1-WORD_W*w -: WORD_W];
  endfunction

  // Power-on contents: every word holds its own word address (block*4 + word).
  function automatic logic [BLOCK_W-1:0] block_init(input logic [IDX_W-1:0] idx);
    logic [BLOCK_W-1:0] blk;
    blk = '0;
    for (int w = 0; w < 4; w++) begin
      blk[BLOCK_W-1-WORD_W*w -: WORD_W] = {{(WORD_W-IDX_W-2){1'b0}}, idx, 2'(w)};
    end
    return blk;
  endfunction

endpackage

`default_nettype wire

// File: rtl/main_memory_ctrl_if.sv
// Cache <-> main-memory block interface; the cache is the master, memory the slave.
`default_nettype none

interface main_memory_ctrl_if;
  import main_memory_ctrl_pkg::*;

  logic               isLock;
  logic               isMemRead;
  logic [31:0]        memAddress;
  logic [BLOCK_W-1:0] memWriteData;
  logic [BLOCK_W-1:0] memReadData;
  logic               memReady;
  logic               memErr;

  modport master (
    output isLock, isMemRead, memAddress, memWriteData,
    input  memReadData, memReady, memErr
  );

  modport slave (
    input  isLock, isMemRead, memAddress, memWriteData,
    output memReadData, memReady, memErr
  );

endinterface

`default_nettype wire

// File: rtl/main_memory_ctrl_mem_block_array.sv
// Block storage: synchronous write port, combinational read port, fixed power-on pattern.
`default_nettype none

module mem_block_array
  import main_memory_ctrl_pkg::*;
#(
  parameter int NUM_BLOCKS = 64
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   widx_i,
  input  logic [BLOCK_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]   ridx_i,
  output logic [BLOCK_W-1:0] rdata_o
);

  logic [BLOCK_W-1:0]    mem_q [NUM_BLOCKS];
  // Blocks never written still return the power-on pattern; reset leaves this alone.
  logic [NUM_BLOCKS-1:0] written_q = '0;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[widx_i]     <= wdata_i;
      written_q[widx_i] <= 1'b1;
    end
  end

  assign rdata_o = written_q[ridx_i] ? mem_q[ridx_i] : block_init(ridx_i);

endmodule

`default_nettype wire

// File: rtl/main_memory_ctrl.sv
// Main-memory responder: captures one block request, waits LATENCY cycles, then
// commits the read/write and pulses memReady (with memErr for out-of-range addresses).
`default_nettype none

module main_memory_ctrl
  import main_memory_ctrl_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int NUM_BLOCKS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  main_memory_ctrl_if.slave   bus
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t             state_q;
  logic [3:0]         cnt_q;
  logic               is_read_q;
  logic [IDX_W-1:0]   idx_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic               flag_q;
  logic [BLOCK_W-1:0] rdata_q;
  logic               ready_q;
  logic               err_q;

  logic               commit;
  logic               store_we;
  logic [BLOCK_W-1:0] store_rdata;
  logic               addr_lo_unused;

  assign addr_lo_unused = ^bus.memAddress[3:0];

  // The final BUSY edge is the DONE transition: storage and outputs update together.
  assign commit   = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign store_we = commit && !is_read_q;

  mem_block_array #(
    .NUM_BLOCKS (NUM_BLOCKS)
  ) u_array (
    .clk     (clk),
    .we_i    (store_we),
    .widx_i  (idx_q),
    .wdata_i (wdata_q),
    .ridx_i  (idx_q),
    .rdata_o (store_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      is_read_q <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      flag_q    <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!bus.isLock) begin
            is_read_q <= bus.isMemRead;
            idx_q     <= bus.memAddress[9:4];
            wdata_q   <= bus.memWriteData;
            flag_q    <= |bus.memAddress[31:10];
            cnt_q     <= CNT_INIT;
            state_q   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q == 4'd0) begin
            if (is_read_q) begin
              rdata_q <= store_rdata;
            end
            ready_q <= 1'b1;
            err_q   <= flag_q;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        // A lock still held after completion must be released before the next request.
        ST_DONE:     state_q <= bus.isLock ? ST_IDLE : ST_WAIT_REL;
        ST_WAIT_REL: if (bus.isLock) state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.memReadData = rdata_q;
  assign bus.memReady    = ready_q;
  assign bus.memErr      = err_q;

endmodule

`default_nettype wire
